// File: rtl/ct_fadd_close_s2_h.sv
// ct_fadd_close_s2_h: half-precision close-path normalize stage (EX2 -> EX3) with ff1 correction and denormal clamp
module ct_fadd_close_s2_h (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        pipe_flush,
  input  logic        pipe_stall,
  input  logic        ex1_vld,
  input  logic [11:0] ex1_close_sum,
  input  logic        ex1_close_op_chg,
  input  logic [5:0]  ex1_ff1_pred,
  input  logic [4:0]  ex1_expnt,
  input  logic        ex1_sign,
  input  logic [2:0]  ex1_rm,
  output logic        ex3_vld,
  output logic [11:0] ex3_mant,
  output logic [4:0]  ex3_expnt,
  output logic        ex3_sign,
  output logic        ex3_zero,
  output logic        ex3_denorm,
  output logic        ex3_ff1_err
);
  logic        ex2_vld;
  logic [11:0] ex2_sum;
  logic        ex2_op_chg;
  logic [5:0]  ex2_ff1_pred;
  logic [4:0]  ex2_expnt;
  logic        ex2_sign;
  logic [2:0]  ex2_rm;
  logic [11:0] mag, t, mant;
  logic [3:0]  pred;
  logic [6:0]  want, max_sh, sh;
  logic [4:0]  expnt;
  logic        zero, extra, normal, sign, denorm;
  always_comb begin
    mag    = ex2_op_chg ? 12'd0 - ex2_sum : ex2_sum;
    pred   = ex2_ff1_pred > 6'd11 ? 4'd11 : ex2_ff1_pred[3:0];
    t      = mag << pred;
    zero   = ~|mag;
    extra  = ~t[11] & ~zero;
    want   = {3'd0, pred} + {6'd0, extra};
    max_sh = {2'd0, ex2_expnt} - 7'd1;
    normal = want <= max_sh;
    sh     = normal ? want : max_sh;
    mant   = mag << sh;
    expnt  = (zero | ~normal) ? 5'd0 : ex2_expnt - want[4:0];
    sign   = zero ? (ex2_rm == 3'b010) : ex2_sign ^ ex2_op_chg;
    denorm = ~zero & ~normal;
  end
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ex2_vld      <= 1'b0;
      ex2_sum      <= 12'd0;
      ex2_op_chg   <= 1'b0;
      ex2_ff1_pred <= 6'd0;
      ex2_expnt    <= 5'd0;
      ex2_sign     <= 1'b0;
      ex2_rm       <= 3'd0;
      ex3_vld      <= 1'b0;
      ex3_mant     <= 12'd0;
      ex3_expnt    <= 5'd0;
      ex3_sign     <= 1'b0;
      ex3_zero     <= 1'b0;
      ex3_denorm   <= 1'b0;
      ex3_ff1_err  <= 1'b0;
    end else begin
      ex2_vld <= pipe_flush ? 1'b0 : pipe_stall ? ex2_vld : ex1_vld;
      ex3_vld <= pipe_flush ? 1'b0 : pipe_stall ? ex3_vld : ex2_vld;
      if (ex1_vld & ~pipe_stall) begin
        ex2_sum      <= ex1_close_sum;
        ex2_op_chg   <= ex1_close_op_chg;
        ex2_ff1_pred <= ex1_ff1_pred;
        ex2_expnt    <= ex1_expnt;
        ex2_sign     <= ex1_sign;
        ex2_rm       <= ex1_rm;
      end
      if (ex2_vld & ~pipe_stall) begin
        ex3_mant    <= mant;
        ex3_expnt   <= expnt;
        ex3_sign    <= sign;
        ex3_zero    <= zero;
        ex3_denorm  <= denorm;
        ex3_ff1_err <= extra;
      end
    end
  end
endmodule

// File: tb/tb_ct_fadd_close_s2_h.sv
// tb_ct_fadd_close_s2_h: table, random-vs-model and pipeline-control checks for ct_fadd_close_s2_h
module tb_ct_fadd_close_s2_h;
  logic        clk, rst, pipe_flush, pipe_stall, ex1_vld, ex1_close_op_chg, ex1_sign;
  logic [11:0] ex1_close_sum;
  logic [5:0]  ex1_ff1_pred;
  logic [4:0]  ex1_expnt;
  logic [2:0]  ex1_rm;
  logic        ex3_vld, ex3_sign, ex3_zero, ex3_denorm, ex3_ff1_err;
  logic [11:0] ex3_mant;
  logic [4:0]  ex3_expnt;
  int checks = 0, passes = 0;

  typedef struct {
    logic [11:0] sum;
    logic        chg;
    logic [5:0]  pred;
    logic [4:0]  expnt;
    logic        sign;
    logic [2:0]  rm;
    logic [20:0] exp;
  } vec_t;
  vec_t vq[$];

  ct_fadd_close_s2_h dut (
    .forever_cpuclk(clk), .cpurst(rst), .pipe_flush(pipe_flush), .pipe_stall(pipe_stall),
    .ex1_vld(ex1_vld), .ex1_close_sum(ex1_close_sum), .ex1_close_op_chg(ex1_close_op_chg),
    .ex1_ff1_pred(ex1_ff1_pred), .ex1_expnt(ex1_expnt), .ex1_sign(ex1_sign), .ex1_rm(ex1_rm),
    .ex3_vld(ex3_vld), .ex3_mant(ex3_mant), .ex3_expnt(ex3_expnt), .ex3_sign(ex3_sign),
    .ex3_zero(ex3_zero), .ex3_denorm(ex3_denorm), .ex3_ff1_err(ex3_ff1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] outs();
    return {ex3_vld, ex3_mant, ex3_expnt, ex3_sign, ex3_zero, ex3_denorm, ex3_ff1_err};
  endfunction

  function automatic logic [20:0] pk(logic [11:0] m, logic [4:0] e, logic s, logic z, logic d, logic f);
    return {m, e, s, z, d, f};
  endfunction

  // Reference: integer arithmetic straight from the normalization rules
  function automatic logic [20:0] model(logic [11:0] sum, logic chg, logic [5:0] pr, logic [4:0] e, logic s, logic [2:0] rm);
    int mag, p, want, mx, sh, ex;
    bit extra, dn;
    mag = chg ? (4096 - int'(sum)) % 4096 : int'(sum);
    if (mag == 0) return pk(12'd0, 5'd0, rm == 3'b010, 1'b1, 1'b0, 1'b0);
    p = pr > 11 ? 11 : int'(pr);
    extra = ((mag << p) & 2048) == 0;
    want = p + int'(extra);
    mx = int'(e) - 1;
    dn = want > mx;
    sh = dn ? mx : want;
    ex = dn ? 0 : int'(e) - want;
    return pk(12'((mag << sh) & 4095), 5'(ex), s ^ chg, 1'b0, dn, extra);
  endfunction

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic vld);
    ex1_vld = vld;
    ex1_close_sum = v.sum;
    ex1_close_op_chg = v.chg;
    ex1_ff1_pred = v.pred;
    ex1_expnt = v.expnt;
    ex1_sign = v.sign;
    ex1_rm = v.rm;
  endtask

  task automatic run_stream(input string tag);
    for (int i = 0; i <= vq.size(); i++) begin
      if (i < vq.size()) drive(vq[i], 1'b1);
      else drive(vq[0], 1'b0);
      tick();
      if (i >= 1) check($sformatf("%s%0d", tag, i - 1), outs(), {1'b1, vq[i-1].exp});
    end
  endtask

  vec_t tbl[13];
  vec_t v;

  initial begin
    tbl[0]  = '{12'h300, 1'b0, 6'd2,  5'd15, 1'b0, 3'd0, pk(12'hC00, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{12'h100, 1'b0, 6'd2,  5'd15, 1'b0, 3'd0, pk(12'h800, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1)};
    tbl[2]  = '{12'hF00, 1'b1, 6'd3,  5'd15, 1'b0, 3'd0, pk(12'h800, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[3]  = '{12'h000, 1'b0, 6'd11, 5'd15, 1'b0, 3'd2, pk(12'h000, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[4]  = '{12'h000, 1'b0, 6'd11, 5'd15, 1'b1, 3'd0, pk(12'h000, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[5]  = '{12'h010, 1'b0, 6'd7,  5'd4,  1'b0, 3'd0, pk(12'h080, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[6]  = '{12'h800, 1'b1, 6'd0,  5'd1,  1'b1, 3'd0, pk(12'h800, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[7]  = '{12'h400, 1'b0, 6'd1,  5'd1,  1'b0, 3'd0, pk(12'h400, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[8]  = '{12'h100, 1'b0, 6'd3,  5'd4,  1'b1, 3'd0, pk(12'h800, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[9]  = '{12'h001, 1'b0, 6'd20, 5'd20, 1'b0, 3'd0, pk(12'h800, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[10] = '{12'h001, 1'b0, 6'd63, 5'd5,  1'b0, 3'd0, pk(12'h010, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[11] = '{12'h040, 1'b0, 6'd4,  5'd5,  1'b0, 3'd0, pk(12'h400, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1)};
    tbl[12] = '{12'hFFF, 1'b1, 6'd11, 5'd12, 1'b0, 3'd0, pk(12'h800, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0)};
    rst = 1'b1;
    pipe_flush = 1'b0;
    pipe_stall = 1'b0;
    drive(tbl[0], 1'b0);
    tick();
    check("reset_state", outs(), 22'd0);
    rst = 1'b0;
    tick();
    foreach (tbl[i]) vq.push_back(tbl[i]);
    run_stream("table");
    vq.delete();
    for (int i = 0; i < 300; i++) begin
      v.sum = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom);
      v.chg = v.sum[11];
      v.pred = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 11));
      v.expnt = 5'($urandom_range(1, 31));
      v.sign = 1'($urandom);
      v.rm = 3'($urandom);
      v.exp = model(v.sum, v.chg, v.pred, v.expnt, v.sign, v.rm);
      vq.push_back(v);
    end
    run_stream("rand");
    // async reset with both stages full
    drive(tbl[0], 1'b1);
    tick();
    drive(tbl[1], 1'b1);
    tick();
    check("pre_reset", outs(), {1'b1, tbl[0].exp});
    #3 rst = 1'b1;
    #1 check("async_reset", outs(), 22'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(tbl[0], 1'b0);
    tick();
    check("reset_drops_entries", outs(), 22'd0);
    // stall: entry at N, stall over N+1..N+2
    drive(tbl[1], 1'b1);
    tick();
    pipe_stall = 1'b1;
    tick();
    check("stall_hold1", outs(), 22'd0);
    tick();
    check("stall_hold2", outs(), 22'd0);
    pipe_stall = 1'b0;
    ex1_vld = 1'b0;
    tick();
    check("stall_release", outs(), {1'b1, tbl[1].exp});
    tick();
    check("stall_drain_vld", {21'd0, ex3_vld}, 22'd0);
    // both stages valid, stall holds, then flush over stall
    drive(tbl[2], 1'b1);
    tick();
    drive(tbl[5], 1'b1);
    tick();
    check("fill_ex3", outs(), {1'b1, tbl[2].exp});
    pipe_stall = 1'b1;
    drive(tbl[11], 1'b1);
    tick();
    check("stall_full_hold", outs(), {1'b1, tbl[2].exp});
    pipe_flush = 1'b1;
    tick();
    check("flush_ex3_vld", {21'd0, ex3_vld}, 22'd0);
    check("flush_ex2_vld", {21'd0, dut.ex2_vld}, 22'd0);
    pipe_flush = 1'b0;
    pipe_stall = 1'b0;
    ex1_vld = 1'b0;
    tick();
    check("flush_dropped", {21'd0, ex3_vld}, 22'd0);
    // flush with a fresh ex1 entry and no stall: entry dropped
    drive(tbl[0], 1'b1);
    pipe_flush = 1'b1;
    tick();
    pipe_flush = 1'b0;
    ex1_vld = 1'b0;
    tick();
    check("flush_new_entry", {21'd0, ex3_vld}, 22'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ct_fadd_close_s2_h.md
# ct_fadd_close_s2_h

Half-precision close-path normalization stage of the vector FP adder. It consumes the close-path difference and the leading-one prediction produced in EX1, and forms the magnitude. It then normalizes with one-bit prediction correction and clamps the shift at the denormal boundary. It delivers a registered, normalized mantissa and exponent to the rounding stage over a two-stage pipeline (EX2 and EX3) with stall and flush.

## Interface
Parameters: none (half precision only; widths fixed).

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  asynchronous active-high reset
- pipe_flush  in  1  kill all in-flight entries
- pipe_stall  in  1  hold all pipeline registers
- ex1_vld  in  1  EX1 entry valid
- ex1_close_sum  in  12  close-path two's-complement difference (op0 − op1)
- ex1_close_op_chg  in  1  difference negative (ex1_close_sum[11])
- ex1_ff1_pred  in  6  predicted leading-one distance from bit 11 (0..11)
- ex1_expnt  in  5  effective larger exponent, biased, ≥1
- ex1_sign  in  1  sign of operand 0
- ex1_rm  in  3  rounding mode (3'b010 = RDN)
- ex3_vld  out  1  result valid
- ex3_mant  out  12  normalized mantissa, leading one at bit 11 when normal
- ex3_expnt  out  5  result biased exponent (0 when denormal or zero)
- ex3_sign  out  1  result sign
- ex3_zero  out  1  exact zero result
- ex3_denorm  out  1  shift clamped, result subnormal
- ex3_ff1_err  out  1  prediction was one short, extra shift applied

## Operation
- EX2 register: captures ex1_* on `ex1_vld & ~pipe_stall`. Its data registers load only when the entry is valid.
- EX2 combinational path: the following steps, registered into EX3.
  - Magnitude: mag = op_chg ? (12'd0 − close_sum) : close_sum, taken mod 2^12.
  - Sign: sign = ex1_sign ^ op_chg.
  - Prediction: pred = min(ff1_pred, 11).
  - Prediction check: t = mag << pred. If t[11]==0 and mag≠0, then extra = 1; otherwise extra = 0.
  - Shift: want = pred + extra, computed at 7 bits unsigned. max = expnt − 1.
  - Normal case (want ≤ max): mant = mag << want, expnt_out = expnt − want, denorm = 0.
  - Denormal case (want > max): mant = mag << max, expnt_out = 0, denorm = 1.
  - ff1_err: ff1_err = extra, reported even when the shift is clamped.
  - Zero (mag==0): overrides all other results. zero = 1, mant = 0, expnt_out = 0, denorm = 0, ff1_err = 0, sign = (rm==3'b010).
- EX3 register: loads EX2 results on `ex2_vld & ~pipe_stall`. Its outputs are the register contents directly.
- Valid bits:
  - ex2_vld_next = pipe_flush ? 0 : pipe_stall ? ex2_vld : ex1_vld.
  - ex3_vld_next = pipe_flush ? 0 : pipe_stall ? ex3_vld : ex2_vld.
- Consumption: downstream consumes ex3_* every cycle in which ex3_vld=1 and pipe_stall=0.

## Timing
- Reset: cpurst asynchronously clears every output and internal register to 0.
- Latency: ex1_vld sampled at edge N → ex3_vld=1 after edge N+1. This gives 2-cycle latency and full throughput with no bubbles.
- Stall: holds both stages bit-exact, data and valid. ex1_* is ignored while stalled, and upstream holds it.
- Flush: takes priority over stall. Both valid bits are 0 after the next edge, and data registers are don't-care.
- Simultaneous flush and ex1_vld: the new entry is dropped.
- Reset mid-operation: all in-flight entries are lost, and there is no recovery.
- Boundary conditions:
  - ff1_pred > 11 is clamped to 11.
  - expnt=1 gives max = 0: no shift, and denorm=1 whenever want > 0.
  - When want == max exactly, the result is normal with expnt_out = 1.

## Test plan
- **Normal.** sum=12'h300, op_chg=0, pred=2, expnt=15, sign=0. Required at N+2: vld=1, mant=12'hC00, expnt=13, sign=0, ff1_err=0.
- **Prediction one short.** sum=12'h100, pred=2, expnt=15. Required: mant=12'h800, expnt=12, ff1_err=1.
- **Negative difference.** sum=12'hF00, op_chg=1, pred=3, expnt=15, sign=0. Required: mant=12'h800, expnt=12, sign=1.
- **Zero result.** sum=0, pred=11, rm=3'b010. Required: zero=1, sign=1, mant=0, expnt=0. Repeat with rm=3'b000: sign=0.
- **Denormal clamp.** sum=12'h010, pred=7, expnt=4. Required: mant=12'h080, expnt=0, denorm=1.
- **Stall and flush.**
  - Stall: entry at N, pipe_stall=1 during cycles N+1..N+2. Required: ex3_vld rises after edge N+3, and outputs are held stable while stalled.
  - Flush: pipe_flush=1 together with pipe_stall=1 and both stages valid. Required: ex2_vld=0 and ex3_vld=0 next cycle.
  - Async reset: asserting cpurst mid-stream clears the outputs immediately, without waiting for a clock edge.
